// File: rtl/index_sweeper.sv
// index_sweeper: walks (channel,row,column) with programmable column stride, one tuple per valid/ready transfer
//  ports: clock, reset (async high); start + cfg_* (latched on accepted start);
//         out_valid/out_ready handshake; col/row/chan_index with last_col/last_row/last;
//         busy (sweeping), done (one-cycle pulse after the final transfer)
module index_sweeper #(
  parameter int WIDTH_LOG  = 4,
  parameter int HEIGHT_LOG = 4,
  parameter int CHAN_LOG   = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH_LOG-1:0]  cfg_width_m1,
  input  logic [HEIGHT_LOG-1:0] cfg_height_m1,
  input  logic [CHAN_LOG-1:0]   cfg_chan_m1,
  input  logic [WIDTH_LOG-1:0]  cfg_col_step,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH_LOG-1:0]  col_index,
  output logic [HEIGHT_LOG-1:0] row_index,
  output logic [CHAN_LOG-1:0]   chan_index,
  output logic                  last_col,
  output logic                  last_row,
  output logic                  last,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH_LOG-1:0]  w_m1, step;
  logic [HEIGHT_LOG-1:0] h_m1;
  logic [CHAN_LOG-1:0]   c_m1;
  logic [WIDTH_LOG:0]    next_col;
  logic                  go, fire;
  // column sum kept one bit wider so a stride past the top never wraps into a small column
  assign next_col   = {1'b0, col_index} + {1'b0, step};
  assign last_col   = next_col > {1'b0, w_m1};
  assign last_row   = last_col && row_index == h_m1;
  assign last       = last_row && chan_index == c_m1;
  assign out_valid  = state == RUN;
  assign busy       = state == RUN;
  assign done       = state == DONE;
  assign go         = start && state != RUN;
  assign fire       = out_valid && out_ready;
  always_comb begin
    state_nx = go ? RUN : (fire && last) ? DONE : (state == DONE) ? IDLE : state;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_m1       <= '0;
      h_m1       <= '0;
      c_m1       <= '0;
      step       <= '0;
      col_index  <= '0;
      row_index  <= '0;
      chan_index <= '0;
    end else if (go) begin
      w_m1       <= cfg_width_m1;
      h_m1       <= cfg_height_m1;
      c_m1       <= cfg_chan_m1;
      step       <= cfg_col_step == '0 ? WIDTH_LOG'(1) : cfg_col_step;
      col_index  <= '0;
      row_index  <= '0;
      chan_index <= '0;
    end else if (fire && !last) begin
      col_index  <= last_col ? '0 : next_col[WIDTH_LOG-1:0];
      row_index  <= !last_col ? row_index : last_row ? '0 : row_index + 1'b1;
      chan_index <= last_row ? chan_index + 1'b1 : chan_index;
    end
  end
endmodule
